// File: rtl/clock_activity_monitor.sv
// Declares an asynchronous clock running/lost from rising-edge counts over fixed windows, with
// good-window hysteresis before restore. All outputs are registered and update the cycle after window end.
module clock_activity_monitor #(
    parameter int STAGES        = 2,
    parameter int WINDOW_CYCLES = 64,
    parameter int MIN_EDGES     = 4,
    parameter int GOOD_WINDOWS  = 4,
    parameter int COUNT_WIDTH   = $clog2(WINDOW_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   monitored_clock,
    output logic                   clock_running,
    output logic                   clock_lost,
    output logic                   clock_restored,
    output logic [COUNT_WIDTH-1:0] edge_count
);

    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

    localparam logic [WIN_W-1:0]       WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = COUNT_WIDTH'(WINDOW_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] CNT_MIN   = COUNT_WIDTH'(MIN_EDGES);
    localparam logic [GOOD_W-1:0]      GOOD_MAX  = GOOD_W'(GOOD_WINDOWS);
    localparam logic [GOOD_W-1:0]      GOOD_ONE  = GOOD_W'(1);

    typedef enum logic [1:0] {
        LOST      = 2'd0,
        ACQUIRING = 2'd1,
        RUNNING   = 2'd2
    } state_t;

    state_t                 state;
    logic [STAGES-1:0]      sync;
    logic                   prev;
    logic [WIN_W-1:0]       win_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic [GOOD_W-1:0]      good_cnt;

    logic                   edge_seen;
    logic                   window_end;
    logic                   window_good;
    logic [COUNT_WIDTH-1:0] final_count;
    logic [GOOD_W-1:0]      good_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], monitored_clock};
            prev <= sync[STAGES-1];
        end
    end

    // The edge seen in the window-end cycle is folded into that window's final count.
    always_comb begin
        edge_seen   = sync[STAGES-1] & ~prev;
        window_end  = (win_cnt == WIN_LAST);
        final_count = (edge_seen && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;
        window_good = (final_count >= CNT_MIN);
        good_next   = (good_cnt == GOOD_MAX) ? GOOD_MAX : good_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            win_cnt  <= window_end ? '0 : win_cnt + 1'b1;
            edge_cnt <= window_end ? '0 : final_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= LOST;
            good_cnt       <= '0;
            clock_running  <= 1'b0;
            clock_lost     <= 1'b0;
            clock_restored <= 1'b0;
            edge_count     <= '0;
        end else begin
            clock_lost     <= 1'b0;
            clock_restored <= 1'b0;
            if (window_end) begin
                edge_count <= final_count;
                case (state)
                    LOST: begin
                        if (window_good) begin
                            good_cnt <= GOOD_ONE;
                            if (GOOD_WINDOWS == 1) begin
                                state          <= RUNNING;
                                clock_running  <= 1'b1;
                                clock_restored <= 1'b1;
                            end else begin
                                state <= ACQUIRING;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    ACQUIRING: begin
                        if (window_good) begin
                            good_cnt <= good_next;
                            if (good_next >= GOOD_MAX) begin
                                state          <= RUNNING;
                                clock_running  <= 1'b1;
                                clock_restored <= 1'b1;
                            end
                        end else begin
                            state    <= LOST;
                            good_cnt <= '0;
                        end
                    end
                    RUNNING: begin
                        if (window_good) begin
                            good_cnt <= good_next;
                        end else begin
                            state         <= LOST;
                            good_cnt      <= '0;
                            clock_running <= 1'b0;
                            clock_lost    <= 1'b1;
                        end
                    end
                    default: begin
                        state         <= LOST;
                        good_cnt      <= '0;
                        clock_running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_activity_monitor.sv
// Randomized and directed bench for clock_activity_monitor; a window-level reference model
// predicts every output on every cycle from the sampled monitored_clock history.
module tb_clock_activity_monitor;

    localparam int STG  = 2;
    localparam int W    = 16;
    localparam int MINE = 2;
    localparam int G    = 3;
    localparam int CW   = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mon = 1'b0;
    logic          running, lost, restored;
    logic [CW-1:0] ecount;

    int checks = 0;
    int errors = 0;

    // Reference model state: sampled history since last reset plus window-level bookkeeping.
    bit samp[$];
    int cnt, goods, m_edge, rest_seen;
    bit m_run, m_lost, m_rest;

    clock_activity_monitor #(
        .STAGES(STG), .WINDOW_CYCLES(W), .MIN_EDGES(MINE), .GOOD_WINDOWS(G)
    ) dut (
        .clock(clk),
        .reset(rst),
        .monitored_clock(mon),
        .clock_running(running),
        .clock_lost(lost),
        .clock_restored(restored),
        .edge_count(ecount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit sv(int k);
        return (k < 0) ? 1'b0 : samp[k];
    endfunction

    task automatic model_reset();
        samp.delete();
        cnt = 0; goods = 0; m_edge = 0;
        m_run = 0; m_lost = 0; m_rest = 0;
    endtask

    // A window is good when its rising-edge count reaches MINE; RUNNING means the last G windows were good.
    task automatic model_step();
        int j;
        j = samp.size() - 1;
        if (sv(j - STG) && !sv(j - STG - 1)) cnt++;
        if (cnt > W) cnt = W;
        m_lost = 0;
        m_rest = 0;
        if (j % W == W - 1) begin
            m_edge = cnt;
            if (cnt >= MINE) begin
                if (goods < G) goods++;
                if (!m_run && goods >= G) begin
                    m_run  = 1;
                    m_rest = 1;
                end
            end else begin
                if (m_run) m_lost = 1;
                m_run = 0;
                goods = 0;
            end
            cnt = 0;
        end
    endtask

    task automatic cycle(input bit m);
        @(negedge clk);
        mon = m;
        @(posedge clk);
        samp.push_back(m);
        model_step();
        #1;
        check("running", running, m_run);
        check("lost", lost, m_lost);
        check("restored", restored, m_rest);
        check("edge_count", ecount, m_edge);
        check("pulse_excl", lost & restored, 1'b0);
        if (restored === 1'b1) rest_seen++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_running"}, running, 1'b0);
        check({tag, "_lost"}, lost, 1'b0);
        check({tag, "_restored"}, restored, 1'b0);
        check({tag, "_edge_count"}, ecount, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        mon = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic window(input int n);
        for (int c = 0; c < W; c++) cycle((c < 4 * n) ? ((c % 4) < 2) : 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("init");
        rst = 1'b0;

        // Stuck low, then stuck high.
        repeat (10 * W) cycle(1'b0);
        check("stuck_low_edges", ecount, 0);
        repeat (10 * W) cycle(1'b1);
        check("stuck_high_running", running, 1'b0);

        // Period-4 clock from reset release: running first visible at cycle 48.
        apply_reset();
        for (int k = 0; k < 8 * W; k++) begin
            cycle((k % 4) < 2);
            if (k == 46) check("run_before_48", running, 1'b0);
            if (k == 47) check("run_at_48", running, 1'b1);
        end
        check("period4_edges", ecount, 4);

        // Clock stops while RUNNING.
        repeat (3 * W) cycle(1'b0);
        check("stop_running", running, 1'b0);
        check("stop_edges", ecount, 0);

        // good, good, bad, good x3: restore only after the 6th window.
        rest_seen = 0;
        window(4); window(4); window(1);
        check("after_bad_running", running, 1'b0);
        window(4); window(4);
        check("before_6th_restored", rest_seen, 0);
        window(4);
        check("pattern_restored_once", rest_seen, 1);
        check("pattern_running", running, 1'b1);

        // Period 20: at most one edge per window.
        for (int k = 0; k < 14 * W; k++) begin
            cycle((k % 20) < 10);
            if (k > 3 * W) check("slow_edges_max1", ecount <= 1, 1'b1);
        end
        check("slow_running", running, 1'b0);

        // Randomized segments: stuck levels, periodic toggles, random bits.
        for (int s = 0; s < 40; s++) begin
            int half, len;
            bit lvl;
            half = $urandom_range(0, 7);
            len  = $urandom_range(8, 70);
            lvl  = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                if (half == 0)      cycle(lvl);
                else if (half == 7) cycle(1'($urandom_range(0, 1)));
                else                cycle(((k / half) % 2) == 1);
            end
        end

        // Async reset mid-window in ACQUIRING with two good windows behind it.
        apply_reset();
        for (int k = 0; k < 2 * W + 5; k++) cycle((k % 4) < 2);
        check("pre_async_running", running, 1'b0);
        check("pre_async_edges", ecount, 4);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4 * W; k++) begin
            cycle((k % 4) < 2);
            if (k == 46) check("rerun_before_48", running, 1'b0);
            if (k == 47) check("rerun_at_48", running, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
